// File: rtl/mem_req_ctrl_pkg.sv
// Shared types for the memory request controller: commit-side tag/record types
// plus request, size and FSM state types with small decode helpers.
package commit_pkg;
  localparam int PREG_ADDR_W = 6;
  typedef logic [PREG_ADDR_W-1:0] preg_addr_t;

  typedef struct packed {
    logic       valid;
    preg_addr_t preg;
    logic [31:0] data;
    logic       adel;
    logic       ades;
  } mem_commit_t;
endpackage

package mem_pkg;
  import commit_pkg::*;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    mem_size_t   size;
    logic        store;
    logic        is_signed;
    preg_addr_t  preg;
  } mem_req_t;

  // Encoding 3 is not a legal size; the bus sees it as a word access.
  function automatic mem_size_t norm_size(input logic [1:0] s);
    case (s)
      2'd0:    return SZ_BYTE;
      2'd1:    return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] lo, input mem_size_t s);
    return ((s == SZ_HALF) && lo[0]) || ((s == SZ_WORD) && (lo != 2'b00));
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [31:0] w, input mem_size_t s);
    case (s)
      SZ_BYTE: return {4{w[7:0]}};
      SZ_HALF: return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction
endpackage

// File: rtl/mem_req_ctrl_if.sv
// SRAM-like data bus between the request controller (master) and memory (slave).
interface mem_req_ctrl_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_req_ctrl_load_align.sv
// Picks the addressed byte/half out of a bus read word and sign/zero-extends it.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  mem_size_t   size,
  input  logic        is_signed,
  output logic [31:0] data
);
  logic [7:0]  lane      [4];
  logic [15:0] half_lane [2];
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata[8*gi +: 8];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    assign half_lane[gi] = rdata[16*gi +: 16];
  end

  assign byte_v = lane[addr_lo];
  assign half_v = half_lane[addr_lo[1]];

  always_comb begin
    case (size)
      SZ_BYTE: data = {{24{is_signed & byte_v[7]}}, byte_v};
      SZ_HALF: data = {{16{is_signed & half_v[15]}}, half_v};
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/mem_req_ctrl.sv
// Single-outstanding load/store controller: issue port -> SRAM-like bus -> one
// completion to commit. Flush cancels the completion, never a started bus access.
module mem_req_ctrl
  import mem_pkg::*;
  import commit_pkg::*;
#(
  parameter int PREG_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_issued,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_store,
  input  logic              req_signed,
  input  logic [PREG_W-1:0] req_preg,
  input  logic              flush,
  output logic              wait_mem,
  mem_req_ctrl_if.master    bus,
  output logic              mc_valid,
  output logic [PREG_W-1:0] mc_preg,
  output logic [31:0]       mc_data,
  output logic              mc_adel,
  output logic              mc_ades
);
  mem_state_t  state_q, state_d;
  mem_req_t    req_q, req_d, new_req;
  mem_commit_t mc_q, mc_d;
  logic        killed_q, killed_d;
  logic        mis_q, mis_d;
  logic [31:0] load_data;
  logic        mc_kill;

  // Write data is lane-replicated at accept time so the bus fields come straight from flops.
  always_comb begin
    new_req           = '0;
    new_req.addr      = req_addr;
    new_req.size      = norm_size(req_size);
    new_req.wdata     = lane_replicate(req_wdata, norm_size(req_size));
    new_req.store     = req_store;
    new_req.is_signed = req_signed;
    new_req.preg      = preg_addr_t'(req_preg);
  end

  mem_load_align u_align (
    .rdata     (bus.data_rdata),
    .addr_lo   (req_q.addr[1:0]),
    .size      (req_q.size),
    .is_signed (req_q.is_signed),
    .data      (load_data)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    killed_d = killed_q;
    mis_d    = 1'b0;
    mc_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (mem_issued && !flush) begin
          if (is_misaligned(new_req.addr[1:0], new_req.size)) begin
            mis_d      = 1'b1;
            mc_d.valid = 1'b1;
            mc_d.preg  = new_req.preg;
            mc_d.data  = new_req.addr;
            mc_d.adel  = ~new_req.store;
            mc_d.ades  = new_req.store;
          end else begin
            req_d   = new_req;
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (flush) killed_d = 1'b1;
        if (bus.data_addr_ok) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (flush) killed_d = 1'b1;
        if (bus.data_data_ok) begin
          state_d  = ST_IDLE;
          killed_d = 1'b0;
          if (!killed_q && !flush) begin
            mc_d.valid = 1'b1;
            mc_d.preg  = req_q.preg;
            mc_d.data  = req_q.store ? 32'h0 : load_data;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      killed_q <= 1'b0;
      mis_q    <= 1'b0;
      mc_q     <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      killed_q <= killed_d;
      mis_q    <= mis_d;
      mc_q     <= mc_d;
    end
  end

  assign wait_mem       = (state_q != ST_IDLE);
  assign bus.data_req   = (state_q == ST_ADDR);
  assign bus.data_wr    = req_q.store;
  assign bus.data_size  = req_q.size;
  assign bus.data_addr  = req_q.addr;
  assign bus.data_wdata = req_q.wdata;

  // A misaligned fault pulse is already visible when its flush window arrives, so gate it here.
  assign mc_kill  = mis_q & flush;
  assign mc_valid = mc_q.valid & ~mc_kill;
  assign mc_preg  = mc_kill ? '0 : PREG_W'(mc_q.preg);
  assign mc_data  = mc_kill ? 32'h0 : mc_q.data;
  assign mc_adel  = mc_q.adel & ~mc_kill;
  assign mc_ades  = mc_q.ades & ~mc_kill;
endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Single-outstanding memory request controller between the issue stage's memory port and the SRAM-like data bus. It accepts one load/store from issue and holds `wait_mem` high while that access is in flight. It drives the bus handshake, aligns and extends load data, and returns one completion (data, destination preg, address-error flags) to commit for ROB writeback. A pipeline flush cancels the completion but never a bus transaction already started.

## Interface
- `PREG_W`, default 6: physical register tag width (matches `preg_addr_t`).
- One clock; reset is asynchronous and active-high. Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `mem_issued`  in  1  issue presents a memory op this cycle
- `req_addr`  in  32  virtual address, already translated
- `req_wdata`  in  32  store data, right-aligned
- `req_size`  in  2  0 byte, 1 half, 2 word; 3 is illegal and treated as word
- `req_store`  in  1  1 store, 0 load
- `req_signed`  in  1  sign-extend load result
- `req_preg`  in  PREG_W  destination tag (ROB entry)
- `flush`  in  1  kill any uncompleted op
- `wait_mem`  out  1  controller busy; issue must not assert `mem_issued`
- `data_req`, `data_wr`  out  1 each  bus request, write enable
- `data_size`  out  2  bus size
- `data_addr`, `data_wdata`  out  32 each  bus address, lane-replicated write data
- `data_addr_ok`, `data_data_ok`  in  1 each  bus handshakes
- `data_rdata`  in  32  bus read data
- `mc_valid`  out  1  completion pulse to commit
- `mc_preg`  out  PREG_W  completion tag
- `mc_data`  out  32  load result; 0 for stores; faulting address on error
- `mc_adel`, `mc_ades`  out  1 each  load or store address error

## Operation
- States:
  - IDLE: free.
  - ADDR: `data_req` high; fields frozen until `data_addr_ok`.
  - DATA: waiting for `data_data_ok`.
- Accept: in IDLE, `mem_issued=1` and `flush=0` latches the request. `flush` has priority and drops a same-cycle issue.
- Misaligned accept (half with addr[0]=1; word with addr[1:0]≠0):
  - No bus access; state stays IDLE.
  - Next cycle `mc_valid=1`, `mc_adel`=~store, `mc_ades`=store, `mc_data`=addr.
- Aligned accept → ADDR. `data_addr`=addr. `data_wdata`:
  - byte: byte replicated ×4
  - half: half replicated ×2
  - word: as given
- ADDR --`data_addr_ok`--> DATA.
- DATA --`data_data_ok`--> IDLE, with the completion registered.
- `data_data_ok` is ignored outside DATA, including in the same cycle as `data_addr_ok`.
- Load align:
  - byte = `rdata[8*addr[1:0] +: 8]`
  - half = `rdata[16*addr[1] +: 16]`
  - Result is sign- or zero-extended per `req_signed`.
- `mem_issued` while `wait_mem=1` is a protocol violation and is ignored.
- Flush:
  - In ADDR or DATA, sets `killed`. The bus transaction still runs to `data_data_ok`, and no completion pulse is produced.
  - Flush in the same cycle as `data_data_ok` also suppresses the completion.
  - Flush in the cycle after a misaligned accept suppresses that completion.
  - `killed` clears on return to IDLE.

## Timing
- Reset: state IDLE, `killed`=0, and all outputs 0 (`wait_mem`, `data_*`, `mc_*`).
- `wait_mem` = (state≠IDLE), taken from registered state only.
- `data_req` = (state==ADDR). Bus outputs are registers, stable through ADDR.
- Best-case load:
  - issue at edge 0
  - `data_req` high in cycle 1 with `addr_ok`
  - `data_ok` in cycle 2
  - `mc_valid` in cycle 3, with `wait_mem` low in cycle 3
  - The next op can issue in cycle 3.
- `mc_*` is a one-cycle registered pulse. `mc_preg` and `mc_data` are held only during that pulse.
- Reset mid-transaction returns to IDLE at once. The bus master is reset on the same signal.

## Structure
- Package `mem_pkg` holds:
  - `mem_size_t` (BYTE/HALF/WORD)
  - `mem_state_t`
  - `mem_req_t` (addr, wdata, size, store, signed, preg)
- `commit_pkg::mem_commit_t` carries valid/preg/data/adel/ades; the `mc_*` ports map onto it.
- Sub-module `mem_load_align`: combinational extraction and extension from rdata, addr[1:0], size, signed.

## Test plan
- Word load at 0x8000_0010, preg 5; `addr_ok` in cycle 1, `data_ok` in cycle 2 with rdata 0xDEAD_BEEF → cycle 3 `mc_valid=1`, `mc_preg=5`, `mc_data=0xDEAD_BEEF`; `wait_mem` high in cycles 1–2 only.
- Signed byte load at addr 0x…03 with rdata 0x80FF_1234 → `mc_data=0xFFFF_FF80`. Unsigned half at 0x…02 with the same rdata → `0x0000_80FF`.
- Byte store 0xAB at 0x…01; `addr_ok` delayed 3 cycles → `data_req`, `data_addr` and `data_wdata=0xABAB_ABAB` held stable for 4 cycles; `mc_data=0` on completion.
- Word load at 0x…02 → no `data_req`; next cycle `mc_valid=1`, `mc_adel=1`, `mc_data=0x…02`, `wait_mem` never high.
- Flush in DATA, then `data_ok` 2 cycles later → no `mc_valid`; `wait_mem` falls after `data_ok`. A new issue is then accepted normally.
- `flush` and `mem_issued` in the same cycle → request dropped, no `data_req`. Reset asserted in ADDR → all outputs 0 immediately.
